// File: rtl/cmprs_stream_rx.sv
// cmprs_stream_rx: FIFO-buffered CCSDS-123 sample receiver with depth formatting and BIL x/z/y tagging
module cmprs_stream_rx #(
   parameter int X_LEN      = 11,
   parameter int Y_LEN      = 6,
   parameter int Z_LEN      = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_AW    = 5
) (
   input  logic                  sclk,
   input  logic                  rst_n,
   input  logic                  soft_clr,
   input  logic                  cfg_en,
   input  logic [X_LEN-1:0]      cfg_x_max,
   input  logic [Y_LEN-1:0]      cfg_y_max,
   input  logic [Z_LEN-1:0]      cfg_z_max,
   input  logic [4:0]            cfg_depth,
   input  logic                  cfg_signed,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [X_LEN-1:0]      out_x,
   output logic [Y_LEN-1:0]      out_y,
   output logic [Z_LEN-1:0]      out_z,
   output logic                  out_first,
   output logic                  out_last,
   input  logic                  frame_release,
   output logic                  busy,
   output logic                  cfg_err,
   output logic [31:0]           img_bits
);
   localparam int CW = FIFO_AW + 1;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
   state_t state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [X_LEN-1:0] x_max;
   logic [Y_LEN-1:0] y_max;
   logic [Z_LEN-1:0] z_max;
   logic [4:0] depth;
   logic sgn;
   logic push, pop, latch, err_nxt, cfg_ok, x_wrap, y_wrap, z_wrap, last;
   logic [DATA_WIDTH-1:0] head, mask, top;
   assign cfg_ok    = |cfg_x_max && |cfg_y_max && |cfg_z_max && cfg_depth != 5'd0 && cfg_depth <= 5'(DATA_WIDTH);
   assign busy      = state != IDLE;
   // count MSB set means exactly 2**FIFO_AW entries, i.e. full
   assign in_ready  = busy && !count[FIFO_AW];
   assign out_valid = state == RUN && count != '0;
   assign push      = in_valid && in_ready && !soft_clr;
   assign pop       = out_valid && out_ready && !soft_clr;
   assign x_wrap    = out_x == x_max - X_LEN'(1);
   assign z_wrap    = out_z == z_max - Z_LEN'(1);
   assign y_wrap    = out_y == y_max - Y_LEN'(1);
   assign last      = x_wrap && z_wrap && y_wrap;
   assign head      = mem[rd_ptr];
   // mask keeps D low bits; top isolates bit D-1 for the sign test
   assign mask      = ~({DATA_WIDTH{1'b1}} << depth);
   assign top       = mask ^ (mask >> 1);
   assign out_data  = out_valid ? ((head & mask) | ((sgn && |(head & top)) ? ~mask : '0)) : '0;
   assign out_first = out_valid && out_x == '0 && out_y == '0 && out_z == '0;
   assign out_last  = out_valid && last;
   // next state, config latch decision and config error detection
   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      err_nxt   = 1'b0;
      if (soft_clr) state_nxt = IDLE;
      else if (state == IDLE) begin
         latch     = cfg_en && cfg_ok;
         err_nxt   = cfg_en && !cfg_ok;
         state_nxt = latch ? RUN : IDLE;
      end else begin
         err_nxt = cfg_en;
         if (pop && last) state_nxt = HOLD;
         else if (state == HOLD && frame_release) state_nxt = RUN;
      end
   end
   // state, config registers and image size; config survives soft_clr
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cfg_err  <= 1'b0;
         img_bits <= '0;
         x_max    <= '0;
         y_max    <= '0;
         z_max    <= '0;
         depth    <= '0;
         sgn      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cfg_err  <= err_nxt;
         img_bits <= 32'(x_max) * 32'(y_max) * 32'(z_max) * 32'(depth);
         if (latch) begin
            x_max <= cfg_x_max;
            y_max <= cfg_y_max;
            z_max <= cfg_z_max;
            depth <= cfg_depth;
            sgn   <= cfg_signed;
         end
      end
   end
   // FIFO storage, no reset needed since reads are gated by count
   always_ff @(posedge sclk) begin
      if (push) mem[wr_ptr] <= in_data;
   end
   // FIFO pointers and occupancy
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (soft_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // BIL position counters: x fastest, then z, then y
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         out_x <= '0;
         out_y <= '0;
         out_z <= '0;
      end else if (soft_clr) begin
         out_x <= '0;
         out_y <= '0;
         out_z <= '0;
      end else if (pop) begin
         out_x <= x_wrap ? '0 : out_x + 1'b1;
         out_z <= x_wrap ? (z_wrap ? '0 : out_z + 1'b1) : out_z;
         out_y <= (x_wrap && z_wrap) ? (y_wrap ? '0 : out_y + 1'b1) : out_y;
      end
   end
endmodule
